i2s_serializer: RTL and testbench

- Downstream stage of the tone generator. Takes the two 16-bit PCM samples and drives the Pmod I2S DAC (CS4344 class) with a 4-wire serial interface: MCLK, LRCK, SCK and SDIN.
- A free-running divider produces all serial clocks from the 100 MHz system clock.
- Samples are captured once per stereo frame and shifted out MSB first in I2S format (data lags LRCK by one SCK).

---
 rtl/i2s_serializer_pkg.sv | 27 ++
 rtl/i2s_serializer_if.sv | 25 ++
 rtl/i2s_serializer_clk_div.sv | 62 ++++++
 rtl/i2s_serializer.sv | 80 ++++++++
 tb/tb_i2s_serializer.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/i2s_serializer_pkg.sv
// Shared definitions for the I2S DAC output stage: divider tap positions,
// default widths, sample and channel types.
package i2s_serializer_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int CNT_W_DEF  = 10;
   localparam int MCLK_BIT   = 1;
   localparam int SCK_BIT    = 3;
   localparam int LRCK_BIT   = 9;
   localparam int SLOT_LSB   = 4;
   localparam int SLOT_MSB   = 8;
   localparam int SLOT_W     = SLOT_MSB - SLOT_LSB + 1;

   typedef logic [DATA_W_DEF-1:0] sample_t;
   typedef logic [SLOT_W-1:0]     slot_t;

   typedef enum logic {
      CH_LEFT  = 1'b0,
      CH_RIGHT = 1'b1
   } chan_e;

   // One slot is one SCK period; 32 slots make a half-frame.
   function automatic slot_t slot_of(input logic [CNT_W_DEF-1:0] cnt);
      return cnt[SLOT_MSB:SLOT_LSB];
   endfunction

endpackage

// File: rtl/i2s_serializer_if.sv
// Sample input and DAC pin bundle between the tone generator, the serializer
// and the Pmod I2S DAC.
interface i2s_serializer_if
   import i2s_serializer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
);
   logic [DATA_W-1:0] audio_left;
   logic [DATA_W-1:0] audio_right;
   logic              sample_tick;
   logic              audio_mclk;
   logic              audio_lrck;
   logic              audio_sck;
   logic              audio_sdin;

   modport master (
      output audio_left, audio_right,
      input  sample_tick, audio_mclk, audio_lrck, audio_sck, audio_sdin
   );

   modport slave (
      input  audio_left, audio_right,
      output sample_tick, audio_mclk, audio_lrck, audio_sck, audio_sdin
   );
endinterface

// File: rtl/i2s_serializer_clk_div.sv
// Free-running frame counter producing registered MCLK/SCK/LRCK, the frame
// tick, and look-ahead slot/channel decode for the data path.
module i2s_clk_div
   import i2s_serializer_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
)(
   input  logic  clk,
   input  logic  rst,
   output logic  mclk_o,
   output logic  sck_o,
   output logic  lrck_o,
   output logic  tick_o,
   output logic  wrap_o,
   output slot_t slot_nxt_o,
   output chan_e ch_nxt_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mclk_q, mclk_d;
   logic             sck_q, sck_d;
   logic             lrck_q, lrck_d;
   logic             tick_q, tick_d;

   // Outputs are registered from the next count so they line up with the count itself.
   always_comb begin
      cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      wrap_o     = (cnt_q == {CNT_W{1'b1}});
      mclk_d     = cnt_d[MCLK_BIT];
      sck_d      = cnt_d[SCK_BIT];
      lrck_d     = cnt_d[LRCK_BIT];
      tick_d     = wrap_o;
      slot_nxt_o = slot_of(cnt_d);
      if (cnt_d[LRCK_BIT]) begin
         ch_nxt_o = CH_RIGHT;
      end else begin
         ch_nxt_o = CH_LEFT;
      end
   end

   // Counter and clock output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= {CNT_W{1'b0}};
         mclk_q <= 1'b0;
         sck_q  <= 1'b0;
         lrck_q <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         mclk_q <= mclk_d;
         sck_q  <= sck_d;
         lrck_q <= lrck_d;
         tick_q <= tick_d;
      end
   end

   assign mclk_o = mclk_q;
   assign sck_o  = sck_q;
   assign lrck_o = lrck_q;
   assign tick_o = tick_q;

endmodule

// File: rtl/i2s_serializer.sv
// I2S serializer for the CS4344 Pmod DAC: captures a stereo pair once per
// frame and shifts it out MSB first, one SCK behind LRCK.
module i2s_serializer
   import i2s_serializer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
)(
   input logic             clk,
   input logic             rst,
   i2s_serializer_if.slave bus
);
   logic              wrap_s;
   slot_t             slot_nxt_s;
   chan_e             ch_nxt_s;
   logic              mclk_s, sck_s, lrck_s, tick_s;
   logic [DATA_W-1:0] hold_left_q, hold_left_d;
   logic [DATA_W-1:0] hold_right_q, hold_right_d;
   logic              sdin_q, sdin_d;

   // Slot s carries bit DATA_W-s; slot 0 and slots past the sample are zero.
   function automatic logic sdin_bit(input logic [DATA_W-1:0] hold, input slot_t slot);
      logic b;
      b = 1'b0;
      for (int i = 0; i < DATA_W; i++) begin
         b = b | (hold[i] & (slot == slot_t'(DATA_W - i)));
      end
      return b;
   endfunction

   i2s_clk_div #(
      .CNT_W      (CNT_W)
   ) u_clk_div (
      .clk        (clk),
      .rst        (rst),
      .mclk_o     (mclk_s),
      .sck_o      (sck_s),
      .lrck_o     (lrck_s),
      .tick_o     (tick_s),
      .wrap_o     (wrap_s),
      .slot_nxt_o (slot_nxt_s),
      .ch_nxt_o   (ch_nxt_s)
   );

   // Both channels are captured on the same edge so the pair stays coherent.
   always_comb begin
      if (wrap_s) begin
         hold_left_d  = bus.audio_left;
         hold_right_d = bus.audio_right;
      end else begin
         hold_left_d  = hold_left_q;
         hold_right_d = hold_right_q;
      end
      case (ch_nxt_s)
         CH_LEFT:  sdin_d = sdin_bit(hold_left_d, slot_nxt_s);
         CH_RIGHT: sdin_d = sdin_bit(hold_right_d, slot_nxt_s);
         default:  sdin_d = 1'b0;
      endcase
   end

   // Sample hold and serial data registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_left_q  <= {DATA_W{1'b0}};
         hold_right_q <= {DATA_W{1'b0}};
         sdin_q       <= 1'b0;
      end else begin
         hold_left_q  <= hold_left_d;
         hold_right_q <= hold_right_d;
         sdin_q       <= sdin_d;
      end
   end

   assign bus.audio_mclk  = mclk_s;
   assign bus.audio_sck   = sck_s;
   assign bus.audio_lrck  = lrck_s;
   assign bus.sample_tick = tick_s;
   assign bus.audio_sdin  = sdin_q;

endmodule

// File: tb/tb_i2s_serializer.sv
// Directed bench for i2s_serializer: a frame-level model checked every cycle,
// plus literal bit-stream words collected on SCK rises.
module tb_i2s_serializer;
   logic clk;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;

   i2s_serializer_if #(.DATA_W(16)) bus();

   i2s_serializer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [4:0] pins;
   assign pins = {bus.audio_mclk, bus.audio_sck, bus.audio_lrck, bus.sample_tick, bus.audio_sdin};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: cycles since reset release, and the pair taken at each wrap.
   int m_n = 0;
   int m_hl = 0;
   int m_hr = 0;

   always @(posedge clk) begin
      int c, s, hold;
      logic [4:0] e;
      if (rst) begin
         m_n = 0; m_hl = 0; m_hr = 0;
      end else begin
         if (m_n % 1024 == 1023) begin
            m_hl = int'(bus.audio_left);
            m_hr = int'(bus.audio_right);
         end
         m_n++;
      end
      #1;
      c = m_n % 1024;
      s = (c / 16) % 32;
      hold = ((c / 512) % 2 == 1) ? m_hr : m_hl;
      e[4] = 1'((c / 2) % 2);
      e[3] = 1'((c / 8) % 2);
      e[2] = 1'((c / 512) % 2);
      e[1] = (m_n > 0 && c == 0);
      e[0] = (s >= 1 && s <= 16) ? 1'((hold >> (16 - s)) & 1) : 1'b0;
      vectors++;
      if (pins !== e) begin
         miscompares++;
         $display("FAIL cycle_pins n=%0d: got %b, expected %b", m_n, pins, e);
      end
   end

   // Collect each half-frame as a 32-bit word, slot 0 in the MSB.
   logic [31:0] sr;
   int          k = 0;
   int          halves = 0;
   logic [31:0] last_left  = 32'hDEAD_BEEF;
   logic [31:0] last_right = 32'hDEAD_BEEF;

   always @(posedge bus.audio_sck or posedge rst) begin
      if (rst) begin
         k = 0; halves = 0;
         last_left = 32'hDEAD_BEEF; last_right = 32'hDEAD_BEEF;
      end else begin
         sr = {sr[30:0], bus.audio_sdin};
         k++;
         if (k == 32) begin
            if (bus.audio_lrck) last_right = sr;
            else last_left = sr;
            halves++;
            k = 0;
         end
      end
   end

   task automatic wait_c(input int target);
      for (int i = 0; i < 2100; i++) begin
         @(posedge clk);
         #2;
         if (m_n % 1024 == target) return;
      end
      chk("wait_c_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int first_sck, first_lrck, n_m, n_s, n_l, n_t, last_tick;
      logic pm, ps, pl;
      rst = 1'b1;
      bus.audio_left  = 16'h0000;
      bus.audio_right = 16'h0000;
      repeat (5) @(posedge clk);
      #1 chk("reset_pins", {27'd0, pins}, 32'd0);
      @(negedge clk) rst = 1'b0;

      first_sck = -1; first_lrck = -1;
      for (int i = 1; i <= 600; i++) begin
         @(posedge clk);
         #1;
         if (bus.audio_sck && first_sck < 0) first_sck = i;
         if (bus.audio_lrck && first_lrck < 0) first_lrck = i;
      end
      chk("first_sck_rise", first_sck, 32'd8);
      chk("first_lrck_rise", first_lrck, 32'd512);

      bus.audio_left  = 16'hA5C3;
      bus.audio_right = 16'h0F0F;
      wait_c(5);
      chk("frame0_left_zero", last_left, 32'h0000_0000);
      chk("frame0_right_zero", last_right, 32'h0000_0000);
      chk("frame0_halves", halves, 32'd2);

      wait_c(300);
      bus.audio_left = 16'hFFFF;
      wait_c(1000);
      bus.audio_left = 16'h1234;
      wait_c(5);
      chk("a5c3_left", last_left, 32'h52E1_8000);
      chk("0f0f_right", last_right, 32'h0787_8000);

      bus.audio_left  = 16'h8000;
      bus.audio_right = 16'h0001;
      wait_c(5);
      chk("late_change_left", last_left, 32'h091A_0000);
      chk("late_change_right", last_right, 32'h0787_8000);

      bus.audio_left  = 16'h0000;
      bus.audio_right = 16'hE000;
      wait_c(5);
      chk("msb_only_left", last_left, 32'h4000_0000);
      chk("lsb_only_right", last_right, 32'h0000_8000);

      bus.audio_left  = 16'hFFFF;
      bus.audio_right = 16'hFFFF;
      wait_c(5);
      chk("silence_left", last_left, 32'h0000_0000);
      chk("negative_right", last_right, 32'h7000_0000);

      pm = bus.audio_mclk; ps = bus.audio_sck; pl = bus.audio_lrck;
      n_m = 0; n_s = 0; n_l = 0; n_t = 0; last_tick = -1;
      for (int i = 0; i < 4096; i++) begin
         @(posedge clk);
         #1;
         if (bus.audio_mclk && !pm) n_m++;
         if (bus.audio_sck && !ps) n_s++;
         if (bus.audio_lrck && !pl) n_l++;
         if (bus.sample_tick) begin
            if (last_tick >= 0) chk("tick_spacing", m_n - last_tick, 32'd1024);
            last_tick = m_n;
            n_t++;
         end
         pm = bus.audio_mclk; ps = bus.audio_sck; pl = bus.audio_lrck;
      end
      chk("mclk_periods", n_m, 32'd1024);
      chk("sck_periods", n_s, 32'd256);
      chk("lrck_periods", n_l, 32'd4);
      chk("tick_count", n_t, 32'd4);
      chk("ffff_left", last_left, 32'h7FFF_8000);

      wait_c(700);
      chk("pre_reset_pins", {27'd0, pins}, 32'b01101);
      #1 rst = 1'b1;
      #1 chk("async_reset_pins", {27'd0, pins}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      wait_c(5);
      wait_c(5);
      chk("post_reset_left_zero", last_left, 32'h0000_0000);
      chk("post_reset_right_zero", last_right, 32'h0000_0000);
      wait_c(5);
      chk("post_reset_left_ffff", last_left, 32'h7FFF_8000);
      chk("post_reset_right_ffff", last_right, 32'h7FFF_8000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
